// File: rtl/inst_queue_if.sv
// Fetch/decode handshake bundle for the instruction queue.
// master = fetch + decode side, slave = queue side.
interface inst_queue_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 2
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic            i_valid;
  logic            o_ready;
  logic [31:0]     i_inst;
  logic [XLEN-1:0] i_addr;
  logic [XLEN-1:0] i_addr_4;
  logic            i_t_inst_addr_misaligned;
  logic            i_t_inst_access_fault;
  logic            o_stall;
  logic            o_valid;
  logic            i_ready;
  logic [31:0]     o_inst;
  logic [XLEN-1:0] o_addr;
  logic [XLEN-1:0] o_addr_4;
  logic            o_t_inst_addr_misaligned;
  logic            o_t_inst_access_fault;
  logic [CW-1:0]   o_count;

  modport master (
    output i_valid, i_inst, i_addr, i_addr_4,
           i_t_inst_addr_misaligned, i_t_inst_access_fault, i_ready,
    input  o_ready, o_stall, o_valid, o_inst, o_addr, o_addr_4,
           o_t_inst_addr_misaligned, o_t_inst_access_fault, o_count
  );

  modport slave (
    input  i_valid, i_inst, i_addr, i_addr_4,
           i_t_inst_addr_misaligned, i_t_inst_access_fault, i_ready,
    output o_ready, o_stall, o_valid, o_inst, o_addr, o_addr_4,
           o_t_inst_addr_misaligned, o_t_inst_access_fault, o_count
  );
endinterface

// File: rtl/inst_queue.sv
// Circular instruction FIFO between fetch and decode; redirects flush it,
// faulting fetches are stored with their instruction replaced by a NOP.
module inst_queue #(
  parameter int unsigned DEPTH    = 2,
  parameter logic [31:0] NOP_INST = 32'h0000_0013,
  parameter int unsigned XLEN     = 32
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_flush,
  inst_queue_if.slave  q
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef struct packed {
    logic [31:0]     inst;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] addr_4;
    logic            mis;
    logic            acc;
  } entry_t;

  entry_t        mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic   ready, valid, push, pop;
  entry_t wr_entry, head;

  // Handshake depends only on registered occupancy: no pass-through when full.
  assign ready = (count_q != CW'(DEPTH));
  assign valid = (count_q != CW'(0));
  assign push  = q.i_valid && ready && !i_flush;
  assign pop   = valid && q.i_ready && !i_flush;

  always_comb begin
    wr_entry.inst   = (q.i_t_inst_addr_misaligned || q.i_t_inst_access_fault)
                      ? NOP_INST : q.i_inst;
    wr_entry.addr   = q.i_addr;
    wr_entry.addr_4 = q.i_addr_4;
    wr_entry.mis    = q.i_t_inst_addr_misaligned;
    wr_entry.acc    = q.i_t_inst_access_fault;
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (i_flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      if (push) mem_q[wr_ptr_q] <= wr_entry;
    end
  end

  assign head = valid ? mem_q[rd_ptr_q] : '0;

  assign q.o_ready                  = ready;
  assign q.o_stall                  = !ready;
  assign q.o_valid                  = valid;
  assign q.o_count                  = count_q;
  assign q.o_inst                   = head.inst;
  assign q.o_addr                   = head.addr;
  assign q.o_addr_4                 = head.addr_4;
  assign q.o_t_inst_addr_misaligned = head.mis;
  assign q.o_t_inst_access_fault    = head.acc;
endmodule

// File: tb/tb_inst_queue.sv
// Randomized and directed checks of inst_queue against a queue-based model.
module tb_inst_queue;
  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 2;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  typedef struct {
    logic [31:0]     inst;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] addr_4;
    logic            mis;
    logic            acc;
  } ent_t;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  int   total = 0;
  int   bad   = 0;
  ent_t model [$];

  inst_queue_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus ();

  inst_queue #(.DEPTH(DEPTH), .NOP_INST(NOP), .XLEN(XLEN)) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_flush (flush),
    .q       (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, advance the model, then check outputs at the next negedge.
  task automatic step(input logic r, input logic f, input logic v, input logic [31:0] inst,
                      input logic [XLEN-1:0] addr, input logic mis, input logic acc,
                      input logic rdy);
    ent_t e;
    bit   full, push, pop;
    rst = r; flush = f;
    bus.i_valid = v; bus.i_inst = inst; bus.i_addr = addr; bus.i_addr_4 = addr + 4;
    bus.i_t_inst_addr_misaligned = mis; bus.i_t_inst_access_fault = acc;
    bus.i_ready = rdy;
    full = (model.size() == DEPTH);
    push = v && !full && !f;
    pop  = (model.size() != 0) && rdy && !f;
    if (r || f) begin
      model.delete();
    end else begin
      if (pop) void'(model.pop_front());
      if (push) begin
        e.inst = (mis || acc) ? NOP : inst;
        e.addr = addr; e.addr_4 = addr + 4; e.mis = mis; e.acc = acc;
        model.push_back(e);
      end
    end
    @(negedge clk);
    check("count", 64'(bus.o_count), 64'(model.size()));
    check("valid", 64'(bus.o_valid), 64'(model.size() != 0));
    check("ready", 64'(bus.o_ready), 64'(model.size() != DEPTH));
    check("stall", 64'(bus.o_stall), 64'(model.size() == DEPTH));
    if (model.size() != 0) begin
      e = model[0];
    end else begin
      e.inst = '0; e.addr = '0; e.addr_4 = '0; e.mis = 1'b0; e.acc = 1'b0;
    end
    check("inst",   64'(bus.o_inst),                   64'(e.inst));
    check("addr",   64'(bus.o_addr),                   64'(e.addr));
    check("addr_4", 64'(bus.o_addr_4),                 64'(e.addr_4));
    check("mis",    64'(bus.o_t_inst_addr_misaligned), 64'(e.mis));
    check("acc",    64'(bus.o_t_inst_access_fault),    64'(e.acc));
  endtask

  initial begin
    logic [31:0] ri;
    logic [XLEN-1:0] ra;
    // reset for two cycles with fetch presenting an entry
    step(1, 0, 1, 32'h1111_1111, 32'h100, 0, 0, 0);
    step(1, 0, 1, 32'h2222_2222, 32'h104, 0, 0, 0);
    // streaming 0x0, 0x4, 0x8 with decode always ready
    step(0, 0, 1, 32'hA000_0000, 32'h0, 0, 0, 1);
    step(0, 0, 1, 32'hA000_0001, 32'h4, 0, 0, 1);
    step(0, 0, 1, 32'hA000_0002, 32'h8, 0, 0, 1);
    step(0, 0, 0, 32'h0,         32'h0, 0, 0, 1);
    // fill, attempt a third push while full, then drain
    step(0, 0, 1, 32'hB000_0010, 32'h10, 0, 0, 0);
    step(0, 0, 1, 32'hB000_0014, 32'h14, 0, 0, 0);
    step(0, 0, 1, 32'hB000_0018, 32'h18, 0, 0, 0);
    step(0, 0, 1, 32'hB000_0018, 32'h18, 0, 0, 1);
    step(0, 0, 1, 32'hB000_0018, 32'h18, 0, 0, 1);
    step(0, 0, 0, 32'h0,         32'h0,  0, 0, 1);
    step(0, 0, 0, 32'h0,         32'h0,  0, 0, 1);
    // wrap-around: five push/pop pairs
    for (int i = 0; i < 5; i++)
      step(0, 0, 1, 32'hC000_0000 + 32'(i), 32'(32'h200 + 4 * i), 0, 0, 1);
    step(0, 0, 0, 32'h0, 32'h0, 0, 0, 1);
    // flush at count=2 with concurrent push and pop
    step(0, 0, 1, 32'hD000_0000, 32'h300, 0, 0, 0);
    step(0, 0, 1, 32'hD000_0001, 32'h304, 0, 0, 0);
    step(0, 1, 1, 32'hD000_0002, 32'h308, 0, 0, 1);
    step(0, 0, 1, 32'hD000_0003, 32'h30C, 0, 0, 0);
    step(0, 1, 0, 32'h0,         32'h0,   0, 0, 0);
    step(0, 1, 1, 32'hD000_0004, 32'h310, 0, 0, 0);
    // faulting fetches are stored as NOP
    step(0, 0, 1, 32'hDEAD_BEEF, 32'h2,   1, 0, 0);
    step(0, 0, 1, 32'hCAFE_F00D, 32'h400, 0, 1, 1);
    step(0, 0, 0, 32'h0,         32'h0,   0, 0, 1);
    step(0, 0, 0, 32'h0,         32'h0,   0, 0, 1);
    // randomized traffic, occasional redirect and reset
    for (int i = 0; i < 400; i++) begin
      ri = $urandom;
      ra = XLEN'($urandom) & ~XLEN'(3);
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 3) != 0), ri, ra,
           ($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 2) != 0));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
